// File: rtl/posit_decode.sv
// Sequential posit<32,3> unpacker: sign, regime k, exponent and normalised mantissa.
// Define POSIT_DECODE_LZC_EN to replace the serial regime scan with a one-cycle priority encoder.
module posit_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] posit_in,
    output logic        sign_out,
    output logic [5:0]  k_out,
    output logic [2:0]  exp_out,
    output logic [31:0] mantissa_out,
    output logic        zero_flag,
    output logic        nar_flag,
    output logic        busy,
    output logic        done
);
    localparam int unsigned PW      = 32;
    localparam int unsigned BW      = PW - 1;
    localparam int unsigned KW      = 6;
    localparam int unsigned EW      = 3;
    localparam int unsigned CW      = 5;
    localparam int unsigned RUN_MAX = 31;

    typedef enum logic [1:0] {IDLE, SCAN, EXTRACT, DONE} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   sh, sh_nxt, body;
    logic [CW-1:0]   m, m_nxt;
    logic            r0, r0_nxt;
    logic            sign_nxt, zero_nxt, nar_nxt;
    logic [KW-1:0]   k_nxt, m_ext;
    logic [EW-1:0]   exp_nxt;
    logic [PW-1:0]   mant_nxt;

    assign body  = BW'(posit_in[PW-1] ? -posit_in : posit_in);
    assign m_ext = KW'(m);

`ifdef POSIT_DECODE_LZC_EN
    logic [CW-1:0] cnt, run_m;
    logic [BW-1:0] run_sh;
    logic          stop;

    // Leading-run length over body[29:0] (held in sh[30:1]) matching r0.
    always_comb begin
        cnt  = '0;
        stop = 1'b0;
        for (int i = BW - 1; i >= 1; i--) begin
            if (!stop && (sh[i] == r0)) cnt = cnt + CW'(1);
            else                        stop = 1'b1;
        end
        run_m  = cnt + CW'(1);
        run_sh = (run_m == CW'(RUN_MAX)) ? '0 : (sh << run_m);
    end
`endif

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        m_nxt     = m;
        r0_nxt    = r0;
        sign_nxt  = sign_out;
        zero_nxt  = zero_flag;
        nar_nxt   = nar_flag;
        k_nxt     = k_out;
        exp_nxt   = exp_out;
        mant_nxt  = mantissa_out;
        case (state)
            IDLE: begin
                if (start) begin
                    if (posit_in == '0) begin
                        zero_nxt  = 1'b1;
                        nar_nxt   = 1'b0;
                        sign_nxt  = 1'b0;
                        k_nxt     = '0;
                        exp_nxt   = '0;
                        mant_nxt  = '0;
                        state_nxt = DONE;
                    end else if (posit_in == {1'b1, {BW{1'b0}}}) begin
                        zero_nxt  = 1'b0;
                        nar_nxt   = 1'b1;
                        sign_nxt  = 1'b0;
                        k_nxt     = '0;
                        exp_nxt   = '0;
                        mant_nxt  = '0;
                        state_nxt = DONE;
                    end else begin
                        sign_nxt  = posit_in[PW-1];
                        r0_nxt    = body[BW-1];
                        sh_nxt    = body << 1;
                        m_nxt     = CW'(1);
                        zero_nxt  = 1'b0;
                        nar_nxt   = 1'b0;
                        state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
`ifdef POSIT_DECODE_LZC_EN
                m_nxt     = run_m;
                sh_nxt    = run_sh;
                state_nxt = EXTRACT;
`else
                // One regime bit per cycle; the terminator is consumed on exit.
                if (m == CW'(RUN_MAX)) begin
                    state_nxt = EXTRACT;
                end else if (sh[BW-1] == r0) begin
                    m_nxt  = m + CW'(1);
                    sh_nxt = sh << 1;
                end else begin
                    sh_nxt    = sh << 1;
                    state_nxt = EXTRACT;
                end
`endif
            end
            EXTRACT: begin
                k_nxt     = r0 ? (m_ext - KW'(1)) : (KW'(0) - m_ext);
                exp_nxt   = sh[BW-1 -: EW];
                mant_nxt  = {1'b1, sh[BW-EW-1:0], 3'b000};
                state_nxt = DONE;
            end
            DONE: begin
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sh           <= '0;
            m            <= '0;
            r0           <= 1'b0;
            sign_out     <= 1'b0;
            k_out        <= '0;
            exp_out      <= '0;
            mantissa_out <= '0;
            zero_flag    <= 1'b0;
            nar_flag     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            sh           <= sh_nxt;
            m            <= m_nxt;
            r0           <= r0_nxt;
            sign_out     <= sign_nxt;
            k_out        <= k_nxt;
            exp_out      <= exp_nxt;
            mantissa_out <= mant_nxt;
            zero_flag    <= zero_nxt;
            nar_flag     <= nar_nxt;
            busy         <= (state_nxt == SCAN) || (state_nxt == EXTRACT);
            done         <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_posit_decode.sv
// Scoreboard bench for posit_decode: expected decodes queued at launch, compared when done rises.
module tb_posit_decode;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] posit_in;
    logic        sign_out;
    logic [5:0]  k_out;
    logic [2:0]  exp_out;
    logic [31:0] mantissa_out;
    logic        zero_flag;
    logic        nar_flag;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] word;
        logic        sign;
        logic [5:0]  k;
        logic [2:0]  e;
        logic [31:0] mant;
        logic        zero;
        logic        nar;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];

    posit_decode dut (
        .clk(clk), .rst_n(rst_n), .start(start), .posit_in(posit_in),
        .sign_out(sign_out), .k_out(k_out), .exp_out(exp_out),
        .mantissa_out(mantissa_out), .zero_flag(zero_flag), .nar_flag(nar_flag),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Launch one decode, wait for done, compare, optionally hold start, then release.
    task automatic run(input logic [31:0] w, input logic s, input logic [5:0] k,
                       input logic [2:0] e, input logic [31:0] mn, input logic z,
                       input logic n, input int lat, input int hold);
        exp_t  x;
        int    edges;
        int    bad;
        string t;
        x = '{word: w, sign: s, k: k, e: e, mant: mn, zero: z, nar: n, lat: 8'(lat)};
`ifdef POSIT_DECODE_LZC_EN
        if (!z && !n) x.lat = 8'd3;
`endif
        sb.push_back(x);
        posit_in = w;
        start    = 1'b1;
        @(posedge clk); #1;
        posit_in = $urandom;
        edges = 1;
        bad   = 0;
        while (!done && edges < 100) begin
            if (!busy) bad++;
            @(posedge clk); #1;
            edges++;
        end
        x = sb.pop_front();
        t = $sformatf("%08h", x.word);
        check({t, " done"}, 64'(done), 64'd1);
        check({t, " latency"}, 64'(edges), 64'(x.lat));
        check({t, " busy_gap"}, 64'(bad), 64'd0);
        check({t, " busy_at_done"}, 64'(busy), 64'd0);
        check({t, " sign"}, 64'(sign_out), 64'(x.sign));
        check({t, " k"}, 64'(k_out), 64'(x.k));
        check({t, " exp"}, 64'(exp_out), 64'(x.e));
        check({t, " mant"}, 64'(mantissa_out), 64'(x.mant));
        check({t, " zero"}, 64'(zero_flag), 64'(x.zero));
        check({t, " nar"}, 64'(nar_flag), 64'(x.nar));
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!done || busy) bad++;
        end
        if (hold > 0) check({t, " hold_done"}, 64'(bad), 64'd0);
        start = 1'b0;
        @(posedge clk); #1;
        check({t, " done_clear"}, 64'(done), 64'd0);
        check({t, " keep_k"}, 64'(k_out), 64'(x.k));
        check({t, " keep_mant"}, 64'(mantissa_out), 64'(x.mant));
        check({t, " keep_sign"}, 64'(sign_out), 64'(x.sign));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        posit_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({sign_out, k_out, exp_out, mantissa_out, zero_flag, nar_flag, busy, done}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort a long scan with reset, then confirm a clean decode follows.
        posit_in = 32'h0000_0001;
        start    = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              64'({sign_out, k_out, exp_out, mantissa_out, zero_flag, nar_flag, busy, done}), 64'd0);
        start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run(32'h4000_0000, 1'b0, 6'd0,  3'd0, 32'h8000_0000, 1'b0, 1'b0, 3,  0);
        run(32'h5A00_0000, 1'b0, 6'd0,  3'd6, 32'hC000_0000, 1'b0, 1'b0, 3,  0);
        run(32'hC000_0000, 1'b1, 6'd0,  3'd0, 32'h8000_0000, 1'b0, 1'b0, 3,  0);
        run(32'h7FFF_FFFF, 1'b0, 6'h1E, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 33, 50);
        run(32'h0000_0001, 1'b0, 6'h22, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32, 0);
        run(32'h0000_0000, 1'b0, 6'd0,  3'd0, 32'h0000_0000, 1'b1, 1'b0, 1,  0);
        run(32'h8000_0000, 1'b0, 6'd0,  3'd0, 32'h0000_0000, 1'b0, 1'b1, 1,  0);
        run(32'hFFFF_FFFF, 1'b1, 6'h22, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32, 0);
        run(32'h4800_0000, 1'b0, 6'd0,  3'd2, 32'h8000_0000, 1'b0, 1'b0, 3,  0);
        run(32'h1C00_0000, 1'b0, 6'h3E, 3'd6, 32'h8000_0000, 1'b0, 1'b0, 4,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
